// File: rtl/alu_issue.sv
// In-order issue/writeback controller for the alu block: register file, per-register
// scoreboard, destination FIFO for in-flight operations, and host preload/readback port.
module alu_issue #(
  parameter int unsigned OPC_W        = 6,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RA_W         = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              instr_vld,
  output logic              instr_rdy,
  input  logic [OPC_W-1:0]  instr_opc,
  input  logic [RA_W-1:0]   instr_dst,
  input  logic [RA_W-1:0]   instr_src0,
  input  logic [RA_W-1:0]   instr_src1,
  output logic              alu_vld,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_operand0,
  output logic [DATA_W-1:0] alu_operand1,
  input  logic              alu_result_vld,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              host_wr_en,
  output logic              host_wr_rdy,
  input  logic [RA_W-1:0]   host_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NREG  = 1 << RA_W;
  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] regfile [NREG];
  logic [RA_W-1:0]   dst_fifo [MAX_INFLIGHT];
  logic [NREG-1:0]   pending, pending_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              alu_vld_q;

  logic              pop_req, fifo_empty, pop, wb_hit, room, issue, host_wr;
  logic              hz_src0, hz_src1, hz_dst;
  logic [RA_W-1:0]   head;
  logic [DATA_W-1:0] opnd0, opnd1;

  // Writeback side: a result pops the FIFO head; r0 never receives the data.
  assign pop_req    = ce & alu_result_vld;
  assign fifo_empty = (count == '0);
  assign pop        = pop_req & ~fifo_empty;
  assign head       = dst_fifo[rd_ptr];
  assign wb_hit     = pop & (head != '0);

  // A pending register whose result lands this cycle is not a hazard (it is forwarded).
  assign hz_src0 = pending[instr_src0] & ~(wb_hit && (head == instr_src0));
  assign hz_src1 = pending[instr_src1] & ~(wb_hit && (head == instr_src1));
  assign hz_dst  = pending[instr_dst]  & ~(wb_hit && (head == instr_dst));
  assign room    = (count < CNT_W'(MAX_INFLIGHT)) | pop;

  assign instr_rdy = ce & instr_vld & room & ~hz_src0 & ~hz_src1 & ~hz_dst;
  assign issue     = instr_rdy;

  assign opnd0 = (wb_hit && (head == instr_src0)) ? alu_result : regfile[instr_src0];
  assign opnd1 = (wb_hit && (head == instr_src1)) ? alu_result : regfile[instr_src1];

  // The held issue register is masked while the alu is frozen, so no op is lost.
  assign alu_vld     = alu_vld_q & ce;
  assign busy        = (count != '0) | alu_vld_q;
  assign host_wr_rdy = ce & ~busy & ~instr_vld;
  assign host_wr     = host_wr_en & host_wr_rdy & (host_addr != '0);

  // Set on issue wins over clear on writeback of the same register.
  always_comb begin
    pending_nxt = pending;
    if (wb_hit) pending_nxt[head] = 1'b0;
    if (issue && (instr_dst != '0)) pending_nxt[instr_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_vld_q    <= 1'b0;
      alu_opcode   <= '0;
      alu_operand0 <= '0;
      alu_operand1 <= '0;
      host_rd_data <= '0;
      err          <= 1'b0;
      pending      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else if (ce) begin
      alu_vld_q    <= issue;
      host_rd_data <= regfile[host_addr];
      pending      <= pending_nxt;
      if (issue) begin
        alu_opcode   <= instr_opc;
        alu_operand0 <= opnd0;
        alu_operand1 <= opnd1;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop_req && fifo_empty) err <= 1'b1;
      unique case ({issue, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Destination FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && ce && issue) dst_fifo[wr_ptr] <= instr_dst;
  end

  // Host preload and writeback never collide: host writes require an idle block.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regfile[i] <= '0;
    end else if (ce) begin
      if (wb_hit)  regfile[head]      <= alu_result;
      if (host_wr) regfile[host_addr] <= host_wr_data;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: an in-order ALU model with variable latency, and an
// architectural register model that executes accepted instructions sequentially.
module tb_alu_issue;
  localparam int unsigned OPC_W = 6, DATA_W = 32, RA_W = 4, MAX_INFLIGHT = 4;
  localparam int unsigned NREG = 16;
  localparam logic [OPC_W-1:0] ADD = 6'd0, SUB = 6'd1, XOR = 6'd2, AND = 6'd3;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b1;
  logic instr_vld = 1'b0, instr_rdy;
  logic [OPC_W-1:0] instr_opc = '0;
  logic [RA_W-1:0] instr_dst = '0, instr_src0 = '0, instr_src1 = '0;
  logic alu_vld, alu_result_vld = 1'b0;
  logic [OPC_W-1:0] alu_opcode;
  logic [DATA_W-1:0] alu_operand0, alu_operand1, alu_result = '0;
  logic host_wr_en = 1'b0, host_wr_rdy;
  logic [RA_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wr_data = '0, host_rd_data;
  logic busy, err;

  always #5 clk = ~clk;

  alu_issue #(.OPC_W(OPC_W), .DATA_W(DATA_W), .RA_W(RA_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .instr_vld(instr_vld), .instr_rdy(instr_rdy), .instr_opc(instr_opc),
    .instr_dst(instr_dst), .instr_src0(instr_src0), .instr_src1(instr_src1),
    .alu_vld(alu_vld), .alu_opcode(alu_opcode), .alu_operand0(alu_operand0),
    .alu_operand1(alu_operand1), .alu_result_vld(alu_result_vld), .alu_result(alu_result),
    .host_wr_en(host_wr_en), .host_wr_rdy(host_wr_rdy), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_data(host_rd_data), .busy(busy), .err(err)
  );

  int checks = 0, errors = 0;
  logic [DATA_W-1:0] arch [NREG];
  logic [OPC_W+2*DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] alu_q [$];
  bit ret_en = 1'b0, spur = 1'b0, pend_vld = 1'b0;
  bit acc;
  int unsigned wt;

  function automatic logic [DATA_W-1:0] alu_f(input logic [OPC_W-1:0] opc,
                                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (opc)
      ADD:     return a + b;
      SUB:     return a - b;
      XOR:     return a ^ b;
      AND:     return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Sequential-execution reference: hazards are invisible at this level.
  task automatic model_accept(input logic [OPC_W-1:0] opc, input logic [RA_W-1:0] d,
                              input logic [RA_W-1:0] s0, input logic [RA_W-1:0] s1);
    exp_q.push_back({opc, arch[s0], arch[s1]});
    if (d != '0) arch[d] = alu_f(opc, arch[s0], arch[s1]);
  endtask

  // ALU model plus issue monitor; samples 1 time unit before each rising edge.
  initial begin
    logic [OPC_W+2*DATA_W-1:0] e;
    forever begin
      @(negedge clk); #1;
      alu_result_vld = (ret_en && alu_q.size() > 0) || spur;
      alu_result     = (alu_q.size() > 0) ? alu_q[0] : '0;
      #3;
      if (rst) begin
        alu_q.delete(); exp_q.delete(); pend_vld = 1'b0;
      end else begin
        if (ce && alu_result_vld && alu_q.size() > 0) void'(alu_q.pop_front());
        if (!ce) chk("alu_vld_frozen", 64'(alu_vld), 64'(0));
        else     chk("alu_vld_timing", 64'(alu_vld), 64'(pend_vld));
        if (alu_vld) begin
          chk("issue_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("alu_opcode",   64'(alu_opcode),   64'(e[2*DATA_W +: OPC_W]));
            chk("alu_operand0", 64'(alu_operand0), 64'(e[DATA_W +: DATA_W]));
            chk("alu_operand1", 64'(alu_operand1), 64'(e[0 +: DATA_W]));
          end
          alu_q.push_back(alu_f(alu_opcode, alu_operand0, alu_operand1));
          pend_vld = 1'b0;
        end
        if (instr_vld && instr_rdy) pend_vld = 1'b1;
      end
    end
  end

  task automatic issue(input logic [OPC_W-1:0] opc, input logic [RA_W-1:0] d,
                       input logic [RA_W-1:0] s0, input logic [RA_W-1:0] s1,
                       input bit rnd, output bit ok, output int unsigned waited);
    ok = 1'b0; waited = 0;
    @(negedge clk);
    instr_vld = 1'b1; instr_opc = opc; instr_dst = d; instr_src0 = s0; instr_src1 = s1;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (c > 0) @(negedge clk);
      if (rnd) begin
        ce = ($urandom_range(0, 7) != 0);
        ret_en = ($urandom_range(0, 3) != 0);
      end
      #4;
      if (instr_rdy) begin model_accept(opc, d, s0, s1); ok = 1'b1; end
      else waited++;
      @(posedge clk);
    end
    #1 instr_vld = 1'b0;
    chk("issue_accepted", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      ce = 1'b1; ret_en = 1'b1; instr_vld = 1'b0;
      #4;
      if (!busy && alu_q.size() == 0) done = 1'b1;
    end
    chk("drain_idle", 64'(done), 64'(1));
  endtask

  task automatic host_write(input logic [RA_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    ce = 1'b1; instr_vld = 1'b0; host_wr_en = 1'b1; host_addr = a; host_wr_data = d;
    #4 chk("host_wr_rdy", 64'(host_wr_rdy), 64'(1));
    @(posedge clk);
    #1 host_wr_en = 1'b0;
    if (a != '0) arch[a] = d;
  endtask

  task automatic host_read(input string nm, input logic [RA_W-1:0] a, input logic [DATA_W-1:0] expv);
    @(negedge clk);
    ce = 1'b1; host_addr = a;
    @(negedge clk); #4;
    chk(nm, 64'(host_rd_data), 64'(expv));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < int'(NREG); i++) arch[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NREG); i++) arch[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_alu_vld", 64'(alu_vld), 64'(0));
    chk("rst_alu_opcode", 64'(alu_opcode), 64'(0));
    chk("rst_operand0", 64'(alu_operand0), 64'(0));
    chk("rst_operand1", 64'(alu_operand1), 64'(0));
    chk("rst_host_rd", 64'(host_rd_data), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // Preload and a simple add.
    host_write(4'd1, 32'd5);
    host_write(4'd2, 32'd7);
    ret_en = 1'b0;
    issue(ADD, 4'd3, 4'd1, 4'd2, 1'b0, acc, wt);
    wait_idle();
    host_read("add_r3", 4'd3, 32'd12);
    chk("add_busy", 64'(busy), 64'(0));

    // RAW hazard: second instruction issues in the writeback cycle of r3, forwarded.
    ret_en = 1'b0;
    issue(ADD, 4'd3, 4'd1, 4'd2, 1'b0, acc, wt);
    @(negedge clk);
    instr_vld = 1'b1; instr_opc = ADD; instr_dst = 4'd4; instr_src0 = 4'd3; instr_src1 = 4'd1;
    repeat (3) begin #4 chk("raw_stall", 64'(instr_rdy), 64'(0)); @(negedge clk); end
    ret_en = 1'b1;
    #4;
    chk("raw_wb_vld", 64'(alu_result_vld), 64'(1));
    chk("raw_issue_in_wb", 64'(instr_rdy), 64'(1));
    if (instr_rdy) model_accept(ADD, 4'd4, 4'd3, 4'd1);
    @(posedge clk); #1 instr_vld = 1'b0;
    wait_idle();
    host_read("raw_r4", 4'd4, 32'd17);

    // Full FIFO: four in flight, fifth issues on the first pop, count stays full.
    ret_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(OPC_W'(i), RA_W'(5 + i), 4'd1, 4'd2, 1'b0, acc, wt);
      chk("full_fill_nostall", 64'(wt), 64'(0));
    end
    @(negedge clk);
    instr_vld = 1'b1; instr_opc = XOR; instr_dst = 4'd9; instr_src0 = 4'd1; instr_src1 = 4'd2;
    repeat (2) begin #4 chk("full_stall", 64'(instr_rdy), 64'(0)); @(negedge clk); end
    ret_en = 1'b1;
    #4 chk("full_issue_on_pop", 64'(instr_rdy), 64'(1));
    if (instr_rdy) model_accept(XOR, 4'd9, 4'd1, 4'd2);
    @(posedge clk);
    #1 instr_dst = 4'd10;
    @(negedge clk);
    ret_en = 1'b0;
    #4 chk("full_count_held", 64'(instr_rdy), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    @(posedge clk); #1 instr_vld = 1'b0;
    wait_idle();
    for (int i = 5; i <= 9; i++) host_read("full_readback", RA_W'(i), arch[i]);

    // r0: reads as zero, never stalls, discards writes.
    ret_en = 1'b0;
    issue(ADD, 4'd0, 4'd0, 4'd1, 1'b0, acc, wt);
    issue(SUB, 4'd0, 4'd0, 4'd2, 1'b0, acc, wt);
    chk("r0_no_stall", 64'(wt), 64'(0));
    wait_idle();
    host_read("r0_after_wb", 4'd0, 32'd0);
    host_write(4'd0, 32'hDEAD_BEEF);
    host_read("r0_after_host", 4'd0, 32'd0);

    // ce=0 freezes everything with two ops in flight.
    ret_en = 1'b0;
    issue(SUB, 4'd10, 4'd1, 4'd2, 1'b0, acc, wt);
    issue(AND, 4'd11, 4'd2, 4'd1, 1'b0, acc, wt);
    @(negedge clk);
    ce = 1'b0; ret_en = 1'b1;
    instr_vld = 1'b1; instr_opc = ADD; instr_dst = 4'd12; instr_src0 = 4'd1; instr_src1 = 4'd1;
    repeat (3) begin
      #4;
      chk("ce0_instr_rdy", 64'(instr_rdy), 64'(0));
      chk("ce0_host_wr_rdy", 64'(host_wr_rdy), 64'(0));
      chk("ce0_busy", 64'(busy), 64'(1));
      @(negedge clk);
    end
    ce = 1'b1; instr_vld = 1'b0;
    wait_idle();
    host_read("ce0_r10", 4'd10, 32'hFFFF_FFFE);
    host_read("ce0_r11", 4'd11, 32'd5);

    // Spurious result sets sticky err; reset mid-flight clears busy, err, scoreboard.
    chk("err_clear_before", 64'(err), 64'(0));
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    #4 chk("err_spurious", 64'(err), 64'(1));
    repeat (3) @(negedge clk);
    #4 chk("err_sticky", 64'(err), 64'(1));
    ret_en = 1'b0;
    issue(ADD, 4'd5, 4'd1, 4'd2, 1'b0, acc, wt);
    do_reset();
    #4;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_err", 64'(err), 64'(0));
    issue(ADD, 4'd6, 4'd5, 4'd5, 1'b0, acc, wt);
    chk("rst_mid_scoreboard", 64'(wt), 64'(0));
    wait_idle();
    host_read("rst_mid_regs", 4'd1, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    #4 chk("err_first_after_rst", 64'(err), 64'(1));
    do_reset();

    // Randomized instruction stream with random ce and result timing.
    for (int i = 1; i < 8; i++) host_write(RA_W'(i), DATA_W'($urandom));
    for (int n = 0; n < 150; n++)
      issue(OPC_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7)),
            RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7)), 1'b1, acc, wt);
    wait_idle();
    for (int i = 0; i < int'(NREG); i++) host_read("rand_readback", RA_W'(i), arch[i]);
    chk("final_err", 64'(err), 64'(0));
    chk("final_exp_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- In-order issue/writeback controller that drives the alu block's input side (ce, vld, opcode, operand0, operand1) and consumes its output side (result_vld, result).
- Accepts decoded instructions on a valid/ready stream, reads operands from an internal register file, and blocks hazards with a per-register scoreboard.
- Queues destination addresses for in-flight operations and writes each ALU result back to its destination.

Parameters:
- OPC_W, 6, opcode width; must equal the `Opcode width in alu.h.
- DATA_W, 32, operand/result width; must equal the `Operand width.
- RA_W, 4, register address width; the register file has 2^RA_W entries.
- MAX_INFLIGHT, 4, depth of the destination FIFO (power of 2, minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  global clock enable; also forwarded to alu.ce
- instr_vld  in  1  instruction valid
- instr_rdy  out  1  instruction accepted this cycle when instr_vld=1
- instr_opc  in  OPC_W  opcode
- instr_dst  in  RA_W  destination register
- instr_src0  in  RA_W  source register 0
- instr_src1  in  RA_W  source register 1
- alu_vld  out  1  to alu.vld
- alu_opcode  out  OPC_W  to alu.opcode
- alu_operand0  out  DATA_W  to alu.operand0
- alu_operand1  out  DATA_W  to alu.operand1
- alu_result_vld  in  1  from alu.result_vld
- alu_result  in  DATA_W  from alu.result
- host_wr_en  in  1  register preload write strobe
- host_wr_rdy  out  1  preload write accepted
- host_addr  in  RA_W  preload write / readback address
- host_wr_data  in  DATA_W  preload data
- host_rd_data  out  DATA_W  regfile[host_addr], registered
- busy  out  1  at least one operation in flight
- err  out  1  sticky: alu_result_vld seen with empty FIFO, or FIFO overflow attempt

Behaviour:
- Decided: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - Outputs: alu_vld=0, alu_opcode=0, alu_operand0/1=0, host_rd_data=0, err=0; busy=0 because the FIFO is empty.
  - Internal: all scoreboard bits=0, FIFO empty, all registers=0.
- Reset mid-operation discards in-flight results. alu_result_vld in the first cycle after reset pops nothing and sets err.
- ce=0:
  - All state holds; instr_rdy=0; host_wr_rdy=0.
  - alu_vld drives 0; the alu is frozen through alu.ce.
  - alu_result_vld is ignored.
- Register 0 reads as 0, is never marked pending, and discards all writes.
- Issue condition (combinational instr_rdy), all of the following must hold:
  - ce=1 and instr_vld=1.
  - FIFO count < MAX_INFLIGHT, or a pop occurs this cycle.
  - src0, src1 and dst are each either not pending, or pending but being written back this cycle.
- Issue action (registered, 1-cycle latency):
  - Next cycle alu_vld=1, carrying instr_opc and the operands.
  - Push instr_dst into the FIFO and set pending[dst] (except r0).
- Forwarding: if a source equals the register being written back in the issue cycle, the operand is taken from alu_result, not the regfile.
- Writeback on alu_result_vld=1 with ce=1:
  - Pop the FIFO head.
  - Write alu_result to regfile[head]; the value is visible to regfile reads next cycle.
  - Clear pending[head], unless the same register is set by an issue in the same cycle; set wins.
- Results return in order. The ALU has fixed, unknown latency; the block never reorders.
- Simultaneous push and pop keeps the count unchanged; pointers wrap modulo MAX_INFLIGHT.
- Push when full cannot occur because of instr_rdy gating. A pop on an empty FIFO sets err and is otherwise ignored.
- Host preload:
  - host_wr_rdy = ce & ~busy & ~instr_vld.
  - A write occurs when host_wr_en & host_wr_rdy; writes to r0 are dropped.
  - host_rd_data is registered every cycle while ce=1. A read of an address written in the same cycle returns the old value.
- busy = (FIFO count != 0) | alu_vld.
- Width rules: there is no arithmetic on data. The count register is clog2(MAX_INFLIGHT)+1 bits.

Test Plan:
- Reset then preload: host write r1=5, r2=7; issue opc=ADD dst=3 src0=1 src1=2.
  - Next cycle: alu_vld=1, operand0=5, operand1=7.
  - After result_vld with result=12: host_addr=3 reads 12; busy=0.
- RAW hazard: issue r3=r1+r2, then immediately r4=r3+r1.
  - instr_rdy=0 until the writeback cycle of r3.
  - In that cycle the instruction issues with operand0 forwarded from alu_result (12).
- Full FIFO: MAX_INFLIGHT=4, 4 independent instructions, alu_result_vld held 0.
  - 4 accepted; the 5th sees instr_rdy=0.
  - On the first result_vld the 5th issues the same cycle; count stays 4.
- r0 behaviour: issue dst=0 src0=0.
  - operand0=0; no stall on r0.
  - Writeback discarded: r0 still reads 0.
- ce=0 for 3 cycles with 2 ops in flight.
  - alu_vld=0, instr_rdy=0; result_vld is ignored.
  - After ce=1, both results retire to the correct registers.
- Spurious result_vld with busy=0 sets err=1, which stays 1 until rst. A rst asserted mid-flight clears busy, err and scoreboard in the next cycle.
